// File: rtl/if_prefetch.sv
// Instruction fetch stage: credit-limited sequential prefetch into a small queue,
// with redirects that flush queued instructions and drop every fetch still in flight.
module if_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redir_valid,
  input  logic              redir_mode,
  input  logic [ADDR_W-1:0] redir_base,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic [ADDR_W-1:0] redir_offset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              redir_misalign
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] LOMASK = ADDR_W'(PC_STEP - 1);

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return a & ~LOMASK;
  endfunction

  logic              run;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     count;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [DATA_W-1:0] q_data [QDEPTH];
  logic [ADDR_W-1:0] q_pc   [QDEPTH];

  logic [CW:0]       credits;
  logic [ADDR_W-1:0] tgt_raw;
  logic [ADDR_W-1:0] tgt;
  logic              tgt_misalign;
  logic              fire;
  logic              push;
  logic              pop;

  // Modular addition covers negative two's-complement offsets as well.
  assign tgt_raw      = (redir_mode ? redir_pc : redir_base) + redir_offset;
  assign tgt          = align_pc(tgt_raw);
  assign tgt_misalign = |(tgt_raw & LOMASK);

  assign credits   = {1'b0, count} + {1'b0, outstanding};
  assign imem_req  = run && !redir_valid && (credits < (CW+1)'(QDEPTH));
  assign imem_addr = fetch_pc;
  assign fire      = imem_req && imem_ready;

  // A response is kept only when no stale fetches remain and no redirect is flushing.
  assign push = imem_rvalid && (drop_cnt == '0) && !redir_valid;

  assign inst_valid = (count != '0);
  assign inst_data  = q_data[rptr];
  assign inst_pc    = q_pc[rptr];
  assign pop        = inst_valid && inst_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run            <= 1'b0;
      fetch_pc       <= RESET_PC;
      resp_pc        <= RESET_PC;
      outstanding    <= '0;
      drop_cnt       <= '0;
      count          <= '0;
      wptr           <= '0;
      rptr           <= '0;
      redir_misalign <= 1'b0;
    end else begin
      run            <= 1'b1;
      redir_misalign <= redir_valid && tgt_misalign;
      outstanding    <= outstanding + CW'(fire) - CW'(imem_rvalid);
      if (redir_valid) begin
        fetch_pc <= tgt;
        resp_pc  <= tgt;
        count    <= '0;
        wptr     <= '0;
        rptr     <= '0;
        // Everything still in flight after this cycle belongs to the old stream.
        drop_cnt <= outstanding - CW'(imem_rvalid);
      end else begin
        if (fire)
          fetch_pc <= fetch_pc + STEP;
        if (imem_rvalid && (drop_cnt != '0))
          drop_cnt <= drop_cnt - 1'b1;
        if (push) begin
          wptr    <= wptr + 1'b1;
          resp_pc <= resp_pc + STEP;
        end
        if (pop)
          rptr <= rptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wptr] <= imem_rdata;
      q_pc[wptr]   <= resp_pc;
    end
  end

endmodule
